// File: rtl/branch_lut.sv
// branch_lut: fully associative branch target table, lowest-free fill then round-robin replacement.
// Define LUT_BYPASS_EN to forward a same-cycle write of the fetched PC to the lookup outputs.
module branch_lut #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] pc_fetch,
   output logic        lut_hit,
   output logic        lut_history,
   output logic [15:0] lut_target,
   input  logic        write_en,
   input  logic [32:0] write_data,
   input  logic        clear
);
   logic [DEPTH-1:0] r_valid;
   logic [15:0]      r_tag [DEPTH];
   logic [15:0]      r_off [DEPTH];
   logic [DEPTH-1:0] r_hist;
   logic [PTR_W-1:0] r_ptr;
   logic [15:0]      w_wr_tag;
   logic             w_match;
   logic             w_free;
   logic [PTR_W-1:0] w_match_idx;
   logic [PTR_W-1:0] w_free_idx;
   logic [PTR_W-1:0] w_wr_idx;

   assign w_wr_tag = write_data[32:17];

   // descending scan so the lowest matching/free index wins
   always_comb begin
      w_match     = 1'b0;
      w_match_idx = '0;
      w_free      = 1'b0;
      w_free_idx  = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (r_valid[i] && r_tag[i] == w_wr_tag) begin
            w_match     = 1'b1;
            w_match_idx = PTR_W'(i);
         end
         if (!r_valid[i]) begin
            w_free     = 1'b1;
            w_free_idx = PTR_W'(i);
         end
      end
   end

   assign w_wr_idx = w_match ? w_match_idx : w_free ? w_free_idx : r_ptr;

   always_comb begin
      lut_hit     = 1'b0;
      lut_history = 1'b0;
      lut_target  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_valid[i] && r_tag[i] == pc_fetch) begin
            lut_hit     = 1'b1;
            lut_history = r_hist[i];
            lut_target  = pc_fetch + r_off[i];
         end
      end
`ifdef LUT_BYPASS_EN
      if (write_en && !clear && !rst && w_wr_tag == pc_fetch) begin
         lut_hit     = 1'b1;
         lut_history = write_data[0];
         lut_target  = pc_fetch + write_data[16:1];
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_valid <= '0;
         r_ptr   <= '0;
      end else if (write_en) begin
         r_valid[w_wr_idx] <= 1'b1;
         r_tag[w_wr_idx]   <= w_wr_tag;
         r_off[w_wr_idx]   <= write_data[16:1];
         r_hist[w_wr_idx]  <= write_data[0];
         if (!w_match && !w_free)
            r_ptr <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
      end
   end
endmodule

// File: tb/tb_branch_lut.sv
// tb_branch_lut: directed table scenarios plus random traffic against a slot-array reference model.
module tb_branch_lut;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] pc_fetch;
   logic        lut_hit;
   logic        lut_history;
   logic [15:0] lut_target;
   logic        write_en;
   logic [32:0] write_data;
   logic        clear;
   int n_chk = 0;
   int n_fail = 0;
   bit          m_valid [8];
   logic [15:0] m_tag [8];
   logic [15:0] m_off [8];
   bit          m_hist [8];
   int          m_ptr = 0;

   always #5 clk = ~clk;

   branch_lut dut (
      .clk(clk), .rst(rst), .pc_fetch(pc_fetch), .lut_hit(lut_hit),
      .lut_history(lut_history), .lut_target(lut_target),
      .write_en(write_en), .write_data(write_data), .clear(clear)
   );

   function automatic logic [32:0] wd(input logic [15:0] pc, input logic [15:0] off, input logic h);
      return {pc, off, h};
   endfunction

   function automatic logic [17:0] m_look(input logic [15:0] pc);
      for (int i = 0; i < 8; i++)
         if (m_valid[i] && m_tag[i] == pc) return {1'b1, m_hist[i], 16'(pc + m_off[i])};
      return '0;
   endfunction

   function automatic void m_update(input logic we, input logic [32:0] d, input logic clr, input logic rs);
      int slot = -1;
      if (rs || clr) begin
         for (int i = 0; i < 8; i++) m_valid[i] = 0;
         m_ptr = 0;
         return;
      end
      if (!we) return;
      for (int i = 0; i < 8; i++) if (m_valid[i] && m_tag[i] == d[32:17]) slot = i;
      if (slot < 0) for (int i = 7; i >= 0; i--) if (!m_valid[i]) slot = i;
      if (slot < 0) begin
         slot = m_ptr;
         m_ptr = (m_ptr + 1) % 8;
      end
      m_valid[slot] = 1;
      m_tag[slot]   = d[32:17];
      m_off[slot]   = d[16:1];
      m_hist[slot]  = d[0];
   endfunction

   task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s got={hit,hist,target}=%h exp=%h", tag, got, exp);
      end
   endtask

   // one clock: drive, check lookup before the edge, advance model at the edge
   task automatic cycle(input string tag, input logic we, input logic [32:0] d,
                        input logic clr, input logic rs, input logic [15:0] pc);
      logic [17:0] e;
      write_en = we; write_data = d; clear = clr; rst = rs; pc_fetch = pc;
      #1;
      e = m_look(pc);
`ifdef LUT_BYPASS_EN
      if (we && !clr && !rs && d[32:17] == pc) e = {1'b1, d[0], 16'(pc + d[16:1])};
`endif
      chk(tag, {lut_hit, lut_history, lut_target}, e);
      @(posedge clk);
      m_update(we, d, clr, rs);
      #1;
   endtask

   task automatic look(input string tag, input logic [15:0] pc, input logic [17:0] exp);
      write_en = 0; clear = 0; rst = 0; pc_fetch = pc;
      #1;
      chk(tag, {lut_hit, lut_history, lut_target}, exp);
   endtask

   initial begin
      int r;
      logic [15:0] wpc, fpc;
      rst = 1; write_en = 0; clear = 0; write_data = '0; pc_fetch = '0;
      @(posedge clk);
      m_update(0, '0, 0, 1);
      #1;
      look("reset_miss", 16'h0010, 18'h0);
      cycle("w10", 1, wd(16'h0010, 16'h0005, 1), 0, 0, 16'h0010);
      look("hit10", 16'h0010, {2'b11, 16'h0015});
      cycle("w10b", 1, wd(16'h0010, 16'h0005, 0), 0, 0, 16'h0000);
      look("upd10", 16'h0010, {2'b10, 16'h0015});
      for (int i = 0; i < 7; i++) cycle("fill2x", 1, wd(16'h0020 + 16'(i), 16'h0001, 0), 0, 0, 16'h0010);
      look("keep10", 16'h0010, {2'b10, 16'h0015});
      look("hit26", 16'h0026, {2'b10, 16'h0027});
      cycle("clr1", 0, '0, 1, 0, 16'h0010);
      look("clr_miss", 16'h0010, 18'h0);
      for (int i = 0; i < 8; i++) cycle("fill1xx", 1, wd(16'h0100 + 16'(i), 16'(i), 1), 0, 0, 16'h0100);
      cycle("w200", 1, wd(16'h0200, 16'h0010, 0), 0, 0, 16'h0100);
      look("evict100", 16'h0100, 18'h0);
      look("hit200", 16'h0200, {2'b10, 16'h0210});
      look("hit101", 16'h0101, {2'b11, 16'h0102});
      cycle("w300", 1, wd(16'h0300, 16'h0000, 1), 0, 0, 16'h0300);
      look("evict101", 16'h0101, 18'h0);
      look("hit102", 16'h0102, {2'b11, 16'h0104});
      look("hit300", 16'h0300, {2'b11, 16'h0300});
      cycle("clr2", 0, '0, 1, 0, 16'h0000);
      cycle("wfff0", 1, wd(16'hFFF0, 16'h0020, 1), 0, 0, 16'h0000);
      look("wrap1", 16'hFFF0, {2'b11, 16'h0010});
      cycle("w0005", 1, wd(16'h0005, 16'hFFFE, 0), 0, 0, 16'h0000);
      look("wrap2", 16'h0005, {2'b10, 16'h0003});
      cycle("clr_we", 1, wd(16'h0077, 16'h0001, 1), 1, 0, 16'h0077);
      look("clr_fff0", 16'hFFF0, 18'h0);
      look("clr_drop", 16'h0077, 18'h0);
      for (int i = 0; i < 3; i++) cycle("fill5x", 1, wd(16'h0050 + 16'(i), 16'h0002, 1), 0, 0, 16'h0050);
      cycle("rst_we", 1, wd(16'h0053, 16'h0002, 1), 0, 1, 16'h0050);
      look("rst_miss50", 16'h0050, 18'h0);
      look("rst_miss53", 16'h0053, 18'h0);
      for (int i = 0; i < 9; i++) cycle("fill6x", 1, wd(16'h0060 + 16'(i), 16'h0003, 0), 0, 0, 16'h0060);
      look("evict60", 16'h0060, 18'h0);
      look("hit61", 16'h0061, {2'b10, 16'h0064});
      cycle("clr3", 0, '0, 1, 0, 16'h0000);
      cycle("same40", 1, wd(16'h0040, 16'h0004, 1), 0, 0, 16'h0040);
      look("next40", 16'h0040, {2'b11, 16'h0044});
      repeat (600) begin
         r   = $urandom_range(0, 99);
         wpc = 16'h0100 + 16'($urandom_range(0, 11));
         fpc = ($urandom_range(0, 2) == 0) ? wpc : 16'h0100 + 16'($urandom_range(0, 11));
         cycle("rand", r < 70 || r >= 95, {wpc, 16'($urandom), 1'($urandom)}, r >= 95 && r < 98, r >= 98, fpc);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
